snes_vga_colour_latch: RTL and testbench

//  Parametrised, clocked successor to the combinational SNES button-to-colour decoder.
//  Per-button 2-flop synchroniser, then per-button debouncer.

---
 rtl/snes_vga_colour_latch_pkg.sv | 32 +++
 rtl/snes_vga_colour_latch_btn_debounce.sv | 46 ++++
 rtl/snes_vga_colour_latch.sv | 127 ++++++++++++
 tb/tb_snes_vga_colour_latch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_vga_colour_latch_pkg.sv
// rtl/snes_vga_colour_latch_pkg.sv - shared types, button indices and default palette for the SNES colour latch
package snes_vga_pkg;

  localparam int SNES_COLOR_W = 4;
  localparam int SNES_N_BTN   = 6;

  // One palette entry, red in the most significant channel
  typedef struct packed {
    logic [SNES_COLOR_W-1:0] r;
    logic [SNES_COLOR_W-1:0] g;
    logic [SNES_COLOR_W-1:0] b;
  } rgb_t;

  localparam int BTN_SELECT = 0;
  localparam int BTN_START  = 1;
  localparam int BTN_A      = 2;
  localparam int BTN_B      = 3;
  localparam int BTN_X      = 4;
  localparam int BTN_Y      = 5;

  localparam rgb_t RGB_SELECT = rgb_t'(12'h000);
  localparam rgb_t RGB_START  = rgb_t'(12'hFFF);
  localparam rgb_t RGB_A      = rgb_t'(12'h0FF);
  localparam rgb_t RGB_B      = rgb_t'(12'h00F);
  localparam rgb_t RGB_X      = rgb_t'(12'h0F0);
  localparam rgb_t RGB_Y      = rgb_t'(12'hFF0);

  // Entry i sits at bits [i*12 +: 12], so Select occupies the least significant slot
  localparam logic [SNES_N_BTN*3*SNES_COLOR_W-1:0] DEFAULT_PALETTE =
    {RGB_Y, RGB_X, RGB_B, RGB_A, RGB_START, RGB_SELECT};

endpackage

// File: rtl/snes_vga_colour_latch_btn_debounce.sv
// rtl/snes_vga_colour_latch_btn_debounce.sv - one button: 2-flop synchroniser, stability counter, debounced level
module snes_btn_debounce import snes_vga_pkg::*; #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous active-low button into the clock domain as active-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= ~i_btn_n;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_s2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
      r_stable <= r_s2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/snes_vga_colour_latch.sv
// rtl/snes_vga_colour_latch.sv - debounced SNES buttons to latched VGA colour; optional idle fade under SNES_COLOUR_FADE_EN
module snes_vga_colour_latch import snes_vga_pkg::*; #(
  parameter int N_BTN       = 6,
  parameter int COLOR_W     = 4,
  parameter int DB_CYCLES   = 500000,
  parameter logic [N_BTN*3*COLOR_W-1:0] PALETTE = DEFAULT_PALETTE,
  parameter int IDLE_CYCLES = 25000000,
  parameter int FADE_STEP   = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_n,
  output logic [COLOR_W-1:0]       red,
  output logic [COLOR_W-1:0]       green,
  output logic [COLOR_W-1:0]       blue,
  output logic [N_BTN-1:0]         btn_pressed,
  output logic [$clog2(N_BTN)-1:0] active_idx,
  output logic                     press_pulse
);

  localparam int IDX_W = $clog2(N_BTN);
  localparam int RGB_W = 3 * COLOR_W;

  logic [N_BTN-1:0] w_stable;
  logic             w_any;
  logic [IDX_W-1:0] w_winner;
  logic [RGB_W-1:0] w_rgb;

  logic [RGB_W-1:0] r_rgb;
  logic [IDX_W-1:0] r_idx;
  logic             r_pulse;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    snes_btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_btn_n  (btn_n[gi]),
      .o_stable (w_stable[gi])
    );
  end

  // Fixed-priority encoder: scanning downward leaves the lowest pressed index
  always_comb begin
    w_winner = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_stable[i]) w_winner = IDX_W'(i);
    end
  end

  assign w_any = |w_stable;
  assign w_rgb = PALETTE[w_winner*RGB_W +: RGB_W];

`ifdef SNES_COLOUR_FADE_EN
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int PRE_W  = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

  logic [IDLE_W-1:0] r_idle;
  logic [PRE_W-1:0]  r_pre;
  logic              w_idle_sat;
  logic              w_fade_tick;
  logic [RGB_W-1:0]  w_faded;

  assign w_idle_sat  = (r_idle == IDLE_W'(IDLE_CYCLES));
  assign w_fade_tick = w_idle_sat && (r_pre == PRE_W'(FADE_STEP - 1));

  // Idle timer saturates, then the prescaler paces one-LSB fade steps; any press restarts both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
      r_pre  <= '0;
    end else if (w_any) begin
      r_idle <= '0;
      r_pre  <= '0;
    end else if (!w_idle_sat) begin
      r_idle <= r_idle + 1'b1;
    end else if (w_fade_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Each channel drops by one but never below zero
  always_comb begin
    w_faded = r_rgb;
    for (int c = 0; c < 3; c++) begin
      if (r_rgb[c*COLOR_W +: COLOR_W] != '0)
        w_faded[c*COLOR_W +: COLOR_W] = r_rgb[c*COLOR_W +: COLOR_W] - 1'b1;
    end
  end
`else
  // Fade timing parameters are accepted for interface compatibility but unused in this build
  if (IDLE_CYCLES < 1 || FADE_STEP < 1) begin : g_fade_cfg_unused
  end
`endif

  // Latch the winning colour; strobe only when index or colour actually changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= '0;
      r_idx   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_any) begin
        r_rgb   <= w_rgb;
        r_idx   <= w_winner;
        r_pulse <= (w_winner != r_idx) || (w_rgb != r_rgb);
      end
`ifdef SNES_COLOUR_FADE_EN
      else if (w_fade_tick) begin
        r_rgb <= w_faded;
      end
`endif
    end
  end

  assign red         = r_rgb[3*COLOR_W-1 -: COLOR_W];
  assign green       = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign blue        = r_rgb[COLOR_W-1 -: COLOR_W];
  assign btn_pressed = w_stable;
  assign active_idx  = r_idx;
  assign press_pulse = r_pulse;

endmodule

// File: tb/tb_snes_vga_colour_latch.sv
// tb/tb_snes_vga_colour_latch.sv - scoreboard bench with randomized buttons against a behavioural colour model
module tb_snes_vga_colour_latch;
  import snes_vga_pkg::*;

  localparam int DB    = 4;
  localparam int IDLE  = 16;
  localparam int STEP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] btn_n = 6'h3F;
  logic [3:0] red, green, blue;
  logic [5:0] btn_pressed;
  logic [2:0] active_idx;
  logic       press_pulse;

  snes_vga_colour_latch #(
    .N_BTN       (6),
    .COLOR_W     (4),
    .DB_CYCLES   (DB),
    .IDLE_CYCLES (IDLE),
    .FADE_STEP   (STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn_n),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .btn_pressed (btn_pressed),
    .active_idx  (active_idx),
    .press_pulse (press_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colours listed straight from the button table
  logic [11:0] pal [6] = '{12'h000, 12'hFFF, 12'h0FF, 12'h00F, 12'h0F0, 12'hFF0};

  typedef struct packed {
    logic [5:0]  bp;
    logic [11:0] rgb;
    logic [2:0]  idx;
    logic        pulse;
  } exp_t;

  exp_t        sq[$];
  logic [14:0] pq[$];

  // Model state: raw samples reach the debounce judgement two clocks late
  logic [5:0]  m_delay[$];
  logic [5:0]  m_stable;
  int          m_run[6];
  logic [11:0] m_rgb;
  logic [2:0]  m_idx;
  int          m_quiet;

  task automatic model_reset();
    m_delay.delete();
    m_delay.push_back(6'h00);
    m_delay.push_back(6'h00);
    m_stable = '0;
    foreach (m_run[i]) m_run[i] = 0;
    m_rgb   = '0;
    m_idx   = '0;
    m_quiet = 0;
    sq.delete();
    pq.delete();
  endtask

  task automatic model_step();
    logic [5:0]  seen;
    logic [5:0]  old;
    logic        pulse;
    int          win;
    exp_t        e;
    old  = m_stable;
    seen = m_delay.pop_front();
    m_delay.push_back(~btn_n);
    // A level is accepted once it has disagreed with the debounced value DB times in a row
    for (int i = 0; i < 6; i++) begin
      if (seen[i] == m_stable[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stable[i] = seen[i];
          m_run[i] = 0;
        end
      end
    end
    pulse = 1'b0;
    if (old != 0) begin
      win = 0;
      while (!old[win]) win++;
      pulse   = (3'(win) != m_idx) || (pal[win] != m_rgb);
      m_rgb   = pal[win];
      m_idx   = 3'(win);
      m_quiet = 0;
    end else begin
`ifdef SNES_COLOUR_FADE_EN
      m_quiet++;
      if (m_quiet > IDLE && ((m_quiet - IDLE) % STEP) == 0) begin
        for (int c = 0; c < 3; c++)
          if (m_rgb[c*4 +: 4] != 0) m_rgb[c*4 +: 4] = m_rgb[c*4 +: 4] - 4'd1;
      end
`endif
    end
    e.bp = m_stable; e.rgb = m_rgb; e.idx = m_idx; e.pulse = pulse;
    sq.push_back(e);
    if (pulse) pq.push_back({m_rgb, m_idx});
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Monitor: per-cycle state plus pulse-qualified colour events
  exp_t        mon_e;
  logic [14:0] mon_p;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sq.size() > 0) begin
        mon_e = sq.pop_front();
        check("btn_pressed", 32'(btn_pressed), 32'(mon_e.bp));
        check("rgb", 32'({red, green, blue}), 32'(mon_e.rgb));
        check("active_idx", 32'(active_idx), 32'(mon_e.idx));
        check("press_pulse", 32'(press_pulse), 32'(mon_e.pulse));
      end
      if (press_pulse) begin
        if (pq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got rgb %0h idx %0d expected no pulse", {red, green, blue}, active_idx);
        end else begin
          mon_p = pq.pop_front();
          check("pulse_event", 32'({red, green, blue, active_idx}), 32'(mon_p));
        end
      end
    end
  end

  task automatic drive(input logic [5:0] v);
    @(posedge clk);
    #1 btn_n = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    btn_n = 6'h3F;
    wait_cycles(3);
    check("reset_rgb", 32'({red, green, blue}), 32'h000);
    check("reset_btn_pressed", 32'(btn_pressed), 32'h0);
    check("reset_pulse", 32'(press_pulse), 32'h0);
    check("reset_idx", 32'(active_idx), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(3);

    // A pressed: exact debounce and latch latency
    drive(6'h3B);
    wait_cycles(5);
    check("a_not_yet", 32'(btn_pressed), 32'h00);
    wait_cycles(1);
    check("a_pressed_k6", 32'(btn_pressed), 32'h04);
    wait_cycles(1);
    check("a_rgb_k7", 32'({red, green, blue}), 32'h0FF);
    check("a_idx_k7", 32'(active_idx), 32'd2);
    check("a_pulse_k7", 32'(press_pulse), 32'h1);
    wait_cycles(5);

    // Short glitch on X is rejected
    drive(6'h3F);
    wait_cycles(10);
    drive(6'h2F);
    repeat (2) @(posedge clk);
    drive(6'h3F);
    wait_cycles(10);
    check("glitch_btn_pressed", 32'(btn_pressed), 32'h00);
`ifndef SNES_COLOUR_FADE_EN
    check("glitch_rgb_hold", 32'({red, green, blue}), 32'h0FF);
`endif

    // Y and B together: B wins, then Y after B is released
    drive(6'h17);
    wait_cycles(10);
    check("yb_rgb", 32'({red, green, blue}), 32'h00F);
    check("yb_idx", 32'(active_idx), 32'd3);
    drive(6'h1F);
    wait_cycles(10);
    check("y_rgb", 32'({red, green, blue}), 32'hFF0);
    check("y_idx", 32'(active_idx), 32'd5);

    // Release all: hold or fade to black
    drive(6'h3F);
    wait_cycles(60);
`ifdef SNES_COLOUR_FADE_EN
    check("faded_rgb", 32'({red, green, blue}), 32'h000);
    drive(6'h3D);
    wait_cycles(10);
    check("start_rgb", 32'({red, green, blue}), 32'hFFF);
    drive(6'h3F);
    wait_cycles(60);
    drive(6'h3D);
    wait_cycles(10);
    check("start_restored", 32'({red, green, blue}), 32'hFFF);
    drive(6'h3F);
    wait_cycles(10);
`else
    check("idle_hold_rgb", 32'({red, green, blue}), 32'hFF0);
`endif

    // Reset asserted in the middle of a debounce
    drive(6'h3E);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_rgb", 32'({red, green, blue}), 32'h000);
    check("midrst_btn_pressed", 32'(btn_pressed), 32'h00);
    check("midrst_idx", 32'(active_idx), 32'h0);
    check("midrst_pulse", 32'(press_pulse), 32'h0);
    btn_n = 6'h3F;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized hold lengths around the debounce window
    for (int it = 0; it < 300; it++) begin
      logic [5:0] v;
      v = 6'($urandom);
      if ($urandom_range(0, 3) == 0) v = 6'h3F;
      drive(v);
      repeat ($urandom_range(0, 9)) @(posedge clk);
    end

    drive(6'h3F);
    wait_cycles(20);
    check("pulse_queue_empty", 32'(pq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
